gf3_lazy_mac: RTL and testbench

Sequential GF(3) dot-product engine. It accepts a stream of trit pairs, multiplies each pair and accumulates the products lazily in a 3-bit register that stays congruent mod 3. After a fixed number of terms it emits the unreduced 3-bit result over a valid/ready handshake. It is the producer side of the 3-bit-in / 2-bit-out GF(3) Barrett reduction path and feeds its 3-bit operand input.

---
 rtl/gf3_pkg.sv | 12 +
 rtl/gf3_fold.sv | 35 +++
 rtl/gf3_lazy_mac.sv | 95 +++++++++
 tb/tb_gf3_lazy_mac.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/gf3_pkg.sv
// Shared GF(3) types and constants for the lazy MAC and its fold stage.
package gf3_pkg;

    typedef logic [1:0] trit_t;

    localparam logic [2:0] GF3_Q          = 3'd3;
    localparam logic [3:0] GF3_FOLD_LIMIT = 4'd8;
    localparam logic [3:0] GF3_FOLD_SUB   = 4'd6;

    typedef enum logic {ACC, OUT} state_t;

endpackage

// File: rtl/gf3_fold.sv
// Combinational add-and-fold of a product into the lazy mod-3 accumulator.
// GF3_MAC_REDUCE_EN selects a fully reduced (0..2) result output.
module gf3_fold
    import gf3_pkg::*;
(
    input  logic [2:0] acc,
    input  logic [2:0] p,
    output logic [2:0] acc_next,
    output logic [2:0] result
);

    logic [3:0] s;

    always_comb begin
        s = {1'b0, acc} + {1'b0, p};
        // Subtracting 6 keeps the value congruent mod 3 and back inside 3 bits.
        if (s >= GF3_FOLD_LIMIT) begin
            acc_next = 3'(s - GF3_FOLD_SUB);
        end else begin
            acc_next = s[2:0];
        end
    end

`ifdef GF3_MAC_REDUCE_EN
    logic [2:0] r1;

    always_comb begin
        r1     = (acc_next >= GF3_Q) ? acc_next - GF3_Q : acc_next;
        result = (r1 >= GF3_Q) ? r1 - GF3_Q : r1;
    end
`else
    assign result = acc_next;
`endif

endmodule

// File: rtl/gf3_lazy_mac.sv
// Sequential GF(3) dot-product engine with lazy 3-bit accumulation and a
// valid/ready result port. Define GF3_MAC_REDUCE_EN for a fully reduced out_data.
module gf3_lazy_mac
    import gf3_pkg::*;
#(
    parameter int unsigned N_TERMS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] in_a,
    input  logic [1:0] in_b,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [2:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       err
);

    localparam int unsigned CNT_W = $clog2(N_TERMS + 1);

    state_t           state, state_next;
    logic [2:0]       acc;
    logic [CNT_W-1:0] cnt;
    trit_t            a, b;
    logic [2:0]       p;
    logic [2:0]       acc_next;
    logic [2:0]       result;
    logic             illegal;
    logic             xfer;
    logic             last;

    assign illegal = (in_a == 2'd3) || (in_b == 2'd3);
    assign a       = (in_a == 2'd3) ? '0 : in_a;
    assign b       = (in_b == 2'd3) ? '0 : in_b;
    assign p       = {1'b0, a} * {1'b0, b};
    assign xfer    = in_valid && in_ready;
    assign last    = (cnt == CNT_W'(N_TERMS - 1));

    gf3_fold u_fold (
        .acc      (acc),
        .p        (p),
        .acc_next (acc_next),
        .result   (result)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACC;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            ACC: begin
                in_ready = 1'b1;
                if (in_valid && last) begin
                    state_next = OUT;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = ACC;
                end
            end
            default: state_next = ACC;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            cnt      <= '0;
            out_data <= '0;
            err      <= 1'b0;
        end else if (xfer) begin
            err <= err | illegal;
            if (last) begin
                out_data <= result;
                acc      <= '0;
                cnt      <= '0;
            end else begin
                acc <= acc_next;
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gf3_lazy_mac.sv
// Directed self-checking bench for gf3_lazy_mac (N_TERMS=4 and N_TERMS=1).
module tb_gf3_lazy_mac;

`ifdef GF3_MAC_REDUCE_EN
    localparam logic [2:0] E_BASIC = 3'd1;
    localparam logic [2:0] E_MIXED = 3'd2;
    localparam logic [2:0] E_ILL   = 3'd0;
    localparam logic [2:0] E_ONES  = 3'd1;
    localparam logic [2:0] E_ONE   = 3'd1;
`else
    localparam logic [2:0] E_BASIC = 3'd4;
    localparam logic [2:0] E_MIXED = 3'd5;
    localparam logic [2:0] E_ILL   = 3'd3;
    localparam logic [2:0] E_ONES  = 3'd4;
    localparam logic [2:0] E_ONE   = 3'd4;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] in_a, in_b;
    logic       in_valid, in_ready, out_valid, out_ready, err;
    logic [2:0] out_data;

    logic [1:0] in_a1, in_b1;
    logic       in_valid1, in_ready1, out_valid1, out_ready1, err1;
    logic [2:0] out_data1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gf3_lazy_mac #(.N_TERMS(4)) dut (
        .clk(clk), .rst(rst), .in_a(in_a), .in_b(in_b), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .err(err)
    );

    gf3_lazy_mac #(.N_TERMS(1)) dut1 (
        .clk(clk), .rst(rst), .in_a(in_a1), .in_b(in_b1), .in_valid(in_valid1),
        .in_ready(in_ready1), .out_data(out_data1), .out_valid(out_valid1),
        .out_ready(out_ready1), .err(err1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic xfer(input logic [1:0] a, input logic [1:0] b);
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_result(input string tag, input logic [2:0] exp);
        in_valid = 1'b0;
        check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_data"}, out_data, exp);
        check({tag, "_inrdy"}, in_ready, 1'b0);
        @(posedge clk);
        #1;
        check({tag, "_done_valid"}, out_valid, 1'b0);
        check({tag, "_done_inrdy"}, in_ready, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        in_a = '0; in_b = '0; in_valid = 1'b0; out_ready = 1'b1;
        in_a1 = 2'd2; in_b1 = 2'd2; in_valid1 = 1'b0; out_ready1 = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_inrdy", in_ready, 1'b1);
        check("rst_valid", out_valid, 1'b0);
        check("rst_data", out_data, 3'd0);
        check("rst_err", err, 1'b0);

        // basic: four (2,2) terms
        for (int unsigned i = 0; i < 4; i++) begin
            xfer(2'd2, 2'd2);
            if (i < 3) check("basic_early_valid", out_valid, 1'b0);
        end
        expect_result("basic", E_BASIC);

        // mixed values
        xfer(2'd1, 2'd2);
        xfer(2'd0, 2'd2);
        xfer(2'd2, 2'd1);
        xfer(2'd1, 2'd1);
        expect_result("mixed", E_MIXED);

        // backpressure with ignored input pulses
        out_ready = 1'b0;
        for (int unsigned i = 0; i < 4; i++) xfer(2'd2, 2'd2);
        for (int unsigned i = 0; i < 3; i++) begin
            in_a = 2'd1; in_b = 2'd1; in_valid = (i != 1);
            check("bp_valid", out_valid, 1'b1);
            check("bp_data", out_data, E_BASIC);
            check("bp_inrdy", in_ready, 1'b0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("bp_hold_valid", out_valid, 1'b1);
        @(posedge clk);
        #1;
        check("bp_release_inrdy", in_ready, 1'b1);
        check("bp_release_valid", out_valid, 1'b0);
        for (int unsigned i = 0; i < 4; i++) xfer(2'd1, 2'd1);
        expect_result("bp_next", E_ONES);

        // illegal trit
        xfer(2'd3, 2'd2);
        check("ill_err_first", err, 1'b1);
        for (int unsigned i = 0; i < 3; i++) xfer(2'd1, 2'd1);
        expect_result("ill", E_ILL);
        check("ill_err_sticky", err, 1'b1);

        // reset mid-accumulation
        xfer(2'd2, 2'd2);
        xfer(2'd2, 2'd2);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("mrst_err", err, 1'b0);
        check("mrst_inrdy", in_ready, 1'b1);
        check("mrst_valid", out_valid, 1'b0);
        check("mrst_data", out_data, 3'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            xfer(2'd1, 2'd1);
            if (i < 3) check("mrst_early_valid", out_valid, 1'b0);
        end
        expect_result("mrst", E_ONES);

        // N_TERMS=1 back-to-back
        check("n1_idle_inrdy", in_ready1, 1'b1);
        in_valid1 = 1'b1;
        for (int unsigned i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("n1_inrdy", in_ready1, (i % 2 == 1));
            check("n1_valid", out_valid1, (i % 2 == 0));
            if (i % 2 == 0) check("n1_data", out_data1, E_ONE);
        end
        in_valid1 = 1'b0;
        check("n1_err", err1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
